// File: rtl/restoring_divider.sv
// ---------------------------------------------------------------------------
// restoring_divider
//
// Purpose:
//   4-bit unsigned restoring divider. One quotient bit is produced per clock
//   cycle, MSB of the dividend first, using a 5-bit partial remainder. Its
//   operand width matches the team's 4x4 Wallace multiplier. The states are
//   IDLE, RUN (4 steps) and FINISH (one-cycle done pulse). Start is accepted
//   in IDLE or FINISH and ignored while busy.
//
// Ports:
//   clk          in   1  sole clock, rising edge
//   rst          in   1  synchronous active-high reset
//   start        in   1  request pulse, sampled only when busy=0
//   A            in   4  unsigned dividend, captured on accepted start
//   B            in   4  unsigned divisor, captured on accepted start
//   busy         out  1  high while the RUN steps are in progress
//   done         out  1  one-cycle pulse, Q/R/div_by_zero valid
//   Q            out  4  quotient floor(A/B), held until next completion
//   R            out  4  remainder A - Q*B, held until next completion
//   div_by_zero  out  1  set with done when the captured B was 0
//
// Configuration macro:
//   RESTORING_DIVIDER_ZERO_DETECT_EN
//     defined   : B==0 skips RUN, completes one cycle after accept with
//                 Q=4'hF, R=A, div_by_zero=1
//     undefined : B==0 runs the normal 4 steps (giving Q=4'hF, R=A) and
//                 div_by_zero is tied to 0
// ---------------------------------------------------------------------------
module restoring_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       busy,
    output logic       done,
    output logic [3:0] Q,
    output logic [3:0] R,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [4:0] prem;
    logic [3:0] dvd;
    logic [3:0] dvs;
    logic [3:0] quo;
    logic [1:0] count;

    logic       accept;
    logic       skip_run;
    logic       last_step;
    logic [4:0] shifted;
    logic       fits;
    logic [4:0] prem_next;
    logic [3:0] quo_next;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, subtract the divisor if it fits and record the quotient bit.
    // The partial remainder is always below the divisor after a step, so its
    // MSB never carries real information into the shift.
    always_comb begin
        accept    = start && (state != RUN);
        last_step = (count == 2'd3);
        shifted   = {prem[3:0], dvd[3]};
        fits      = (shifted >= {1'b0, dvs});
        prem_next = fits ? (shifted - {1'b0, dvs}) : shifted;
        quo_next  = {quo[2:0], fits};
`ifdef RESTORING_DIVIDER_ZERO_DETECT_EN
        skip_run  = (B == 4'd0);
`else
        skip_run  = 1'b0;
`endif
    end

    // Next-state logic and status outputs. FINISH can accept a new start,
    // so back-to-back operations never pass through IDLE.
    always_comb begin
        state_next = state;
        busy       = (state == RUN);
        done       = (state == FINISH);
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = skip_run ? FINISH : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                if (accept) begin
                    state_next = skip_run ? FINISH : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and datapath. Operands are captured on accept so later
    // input changes cannot disturb the running division. Results are loaded
    // only on the edge that enters FINISH and are held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prem  <= 5'd0;
            dvd   <= 4'd0;
            dvs   <= 4'd0;
            quo   <= 4'd0;
            count <= 2'd0;
            Q     <= 4'd0;
            R     <= 4'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                dvd   <= A;
                dvs   <= B;
                prem  <= 5'd0;
                quo   <= 4'd0;
                count <= 2'd0;
                if (skip_run) begin
                    Q <= 4'hF;
                    R <= A;
                end
            end else if (state == RUN) begin
                prem  <= prem_next;
                dvd   <= {dvd[2:0], 1'b0};
                quo   <= quo_next;
                count <= count + 2'd1;
                if (last_step) begin
                    Q <= quo_next;
                    R <= prem_next[3:0];
                end
            end
        end
    end

`ifdef RESTORING_DIVIDER_ZERO_DETECT_EN
    // The divide-by-zero flag follows the same load/hold rule as Q and R:
    // set when a zero divisor short-circuits, cleared when a normal run ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_by_zero <= 1'b0;
        end else if (accept && skip_run) begin
            div_by_zero <= 1'b1;
        end else if ((state == RUN) && last_step) begin
            div_by_zero <= 1'b0;
        end
    end
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_restoring_divider
//
// Self-checking bench for restoring_divider. A cycle-level behavioural
// model (integer division plus a busy countdown) predicts busy, done, Q, R
// and div_by_zero; a compare process checks them on every falling edge.
// Directed cases pin the model with hand-computed literals, and a sweep
// covers every (A,B) pair with B != 0 using the arithmetic identity.
// ---------------------------------------------------------------------------
module tb_restoring_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [3:0] Q;
    logic [3:0] R;
    logic       div_by_zero;

    int checks = 0;
    int fails  = 0;

`ifdef RESTORING_DIVIDER_ZERO_DETECT_EN
    localparam bit ZERO_DETECT = 1'b1;
    localparam int ZERO_LAT    = 1;
`else
    localparam bit ZERO_DETECT = 1'b0;
    localparam int ZERO_LAT    = 5;
`endif

    restoring_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .Q           (Q),
        .R           (R),
        .div_by_zero (div_by_zero)
    );

    // 10 time-unit clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports any miss.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference result straight from the arithmetic definition.
    function automatic void refDivide(input logic [3:0] a, input logic [3:0] b,
                                      output logic [3:0] q, output logic [3:0] r,
                                      output logic z);
        if (b == 4'd0) begin
            q = 4'hF;
            r = a;
            z = ZERO_DETECT;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Behavioural model: an accepted operation keeps the block busy for four
    // cycles and then publishes its result with a one-cycle done; a zero
    // divisor with zero detection publishes immediately.
    int         mBusyLeft = 0;
    logic       mDone     = 1'b0;
    logic [3:0] mQ        = 4'd0;
    logic [3:0] mR        = 4'd0;
    logic       mDbz      = 1'b0;
    logic [3:0] pQ        = 4'd0;
    logic [3:0] pR        = 4'd0;
    logic       pDbz      = 1'b0;
    bit         checkEnable = 1'b0;

    always @(posedge clk) begin
        logic wasBusy;
        logic doneNext;
        if (rst) begin
            mBusyLeft = 0;
            mDone     = 1'b0;
            mQ        = 4'd0;
            mR        = 4'd0;
            mDbz      = 1'b0;
        end else begin
            wasBusy  = (mBusyLeft > 0);
            doneNext = 1'b0;
            if (wasBusy) begin
                mBusyLeft = mBusyLeft - 1;
                if (mBusyLeft == 0) begin
                    doneNext = 1'b1;
                    mQ       = pQ;
                    mR       = pR;
                    mDbz     = pDbz;
                end
            end else if (start) begin
                refDivide(A, B, pQ, pR, pDbz);
                if (ZERO_DETECT && (B == 4'd0)) begin
                    doneNext = 1'b1;
                    mQ       = pQ;
                    mR       = pR;
                    mDbz     = pDbz;
                end else begin
                    mBusyLeft = 4;
                end
            end
            mDone = doneNext;
        end
    end

    // Compare DUT against the model on every falling edge once reset has
    // been applied.
    always @(negedge clk) begin
        if (checkEnable) begin
            checkOutput("model_busy", 32'(busy), 32'(mBusyLeft > 0));
            checkOutput("model_done", 32'(done), 32'(mDone));
            checkOutput("model_Q", 32'(Q), 32'(mQ));
            checkOutput("model_R", 32'(R), 32'(mR));
            checkOutput("model_dbz", 32'(div_by_zero), 32'(mDbz));
        end
    end

    // Pulse start with the given operands for one cycle, then scramble the
    // operand inputs and wait (bounded) for done. lat counts edges from the
    // accepting edge to the first falling edge that sees done.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 output int lat, output int busyCycles);
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        A          = ~a;
        B          = b ^ 4'b0101;
        lat        = 1;
        busyCycles = 0;
        while (!done && lat < 20) begin
            if (busy) busyCycles++;
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            checkOutput("done_timeout", 32'(done), 32'd1);
        end
    endtask

    task automatic directedCase(input string name, input logic [3:0] a,
                                input logic [3:0] b, input int eq, input int er,
                                input int ed, input int elat);
        int lat;
        int bc;
        applyStimulus(a, b, lat, bc);
        checkOutput({name, "_latency"}, 32'(lat), 32'(elat));
        checkOutput({name, "_Q"}, 32'(Q), 32'(eq));
        checkOutput({name, "_R"}, 32'(R), 32'(er));
        checkOutput({name, "_dbz"}, 32'(div_by_zero), 32'(ed));
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int bc;
        rst   = 1'b1;
        start = 1'b0;
        A     = 4'd0;
        B     = 4'd0;
        repeat (2) @(negedge clk);
        checkEnable = 1'b1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_Q", 32'(Q), 32'd0);
        checkOutput("reset_R", 32'(R), 32'd0);
        rst = 1'b0;

        // 13/3 with busy-cycle count
        applyStimulus(4'd13, 4'd3, lat, bc);
        checkOutput("d13_3_latency", 32'(lat), 32'd5);
        checkOutput("d13_3_busy_cycles", 32'(bc), 32'd4);
        checkOutput("d13_3_Q", 32'(Q), 32'd4);
        checkOutput("d13_3_R", 32'(R), 32'd1);
        checkOutput("d13_3_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        checkOutput("d13_3_done_one_cycle", 32'(done), 32'd0);
        checkOutput("d13_3_Q_held", 32'(Q), 32'd4);

        directedCase("d7_9", 4'd7, 4'd9, 0, 7, 0, 5);
        directedCase("d15_1", 4'd15, 4'd1, 15, 0, 0, 5);
        directedCase("d15_15", 4'd15, 4'd15, 1, 0, 0, 5);
        directedCase("d0_5", 4'd0, 4'd5, 0, 0, 0, 5);
        directedCase("d9_0", 4'd9, 4'd0, 15, 9, 32'(ZERO_DETECT), ZERO_LAT);

        // Start during RUN must be ignored: 14/4 -> 3 r 2
        @(negedge clk);
        A = 4'd14; B = 4'd4; start = 1'b1;
        @(negedge clk);
        A = 4'd3; B = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("ignore_start_done", 32'(done), 32'd1);
        checkOutput("ignore_start_Q", 32'(Q), 32'd3);
        checkOutput("ignore_start_R", 32'(R), 32'd2);
        @(negedge clk);

        // Reset in the second RUN cycle abandons the operation
        @(negedge clk);
        A = 4'd12; B = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_Q", 32'(Q), 32'd0);
        checkOutput("abort_R", 32'(R), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        directedCase("d10_3", 4'd10, 4'd3, 3, 1, 0, 5);

        // Reset has priority over a simultaneous start
        rst = 1'b1; start = 1'b1; A = 4'd6; B = 4'd2;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        checkOutput("rst_priority_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("rst_priority_busy_after", 32'(busy), 32'd0);

        // Back-to-back: new start accepted in FINISH, 11/2 then 8/3
        applyStimulus(4'd11, 4'd2, lat, bc);
        checkOutput("b2b_first_Q", 32'(Q), 32'd5);
        checkOutput("b2b_first_R", 32'(R), 32'd1);
        A = 4'd8; B = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_done_dropped", 32'(done), 32'd0);
        checkOutput("b2b_busy_again", 32'(busy), 32'd1);
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("b2b_second_latency", 32'(lat), 32'd5);
        checkOutput("b2b_second_Q", 32'(Q), 32'd2);
        checkOutput("b2b_second_R", 32'(R), 32'd2);
        @(negedge clk);

        // Sweep every pair with a non-zero divisor
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                applyStimulus(4'(a), 4'(b), lat, bc);
                checkOutput("sweep_identity", 32'(int'(Q) * b + int'(R)), 32'(a));
                checkOutput("sweep_r_lt_b", 32'(int'(R) < b), 32'd1);
            end
        end
        @(negedge clk);

        checkEnable = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
